// File: rtl/dest_demux_pkg.sv
// ============================================================================
//  Module      : dest_demux_pkg
//  Description : Shared state encodings and destination-field constants for
//                the egress demultiplexer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package dest_demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_BLOCKED = 2'b10
    } state_t;

    // The destination index occupies the top C_DEST_W bits of every word.
    localparam int C_DEST_W   = 2;
    localparam int C_NUM_DEST = 4;

endpackage

`default_nettype wire

// File: rtl/hold_fifo.sv
// ============================================================================
//  Module      : hold_fifo
//  Description : Circular holding buffer with occupancy, full/empty, and a
//                look-ahead of the tag bits of the head after this edge.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hold_fifo #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [DATA_W-1:0]          i_wr_data,
    output logic [DATA_W-1:0]          o_head,
    output logic [TAG_W-1:0]           o_next_tag,
    output logic [$clog2(DEPTH):0]     o_occ_next,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int C_AW    = $clog2(DEPTH);
    localparam int C_OCC_W = C_AW + 1;

    logic [DATA_W-1:0]  r_mem_q [DEPTH];
    logic [C_AW-1:0]    r_wr_ptr_q, w_wr_ptr_d;
    logic [C_AW-1:0]    r_rd_ptr_q, w_rd_ptr_d;
    logic [C_AW-1:0]    w_rd_nxt;
    logic [C_OCC_W-1:0] r_occ_q, w_occ_d;

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_occ_d    = r_occ_q;
        if (flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_occ_d    = '0;
        end else begin
            if (i_push) w_wr_ptr_d = r_wr_ptr_q + 1'b1;
            if (i_pop)  w_rd_ptr_d = r_rd_ptr_q + 1'b1;
            case ({i_push, i_pop})
                2'b10:   w_occ_d = r_occ_q + 1'b1;
                2'b01:   w_occ_d = r_occ_q - 1'b1;
                default: w_occ_d = r_occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_occ_q    <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_occ_q    <= w_occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !flush) r_mem_q[r_wr_ptr_q] <= i_wr_data;
    end

    // Head after the edge: an incoming word becomes head when the buffer drains.
    assign w_rd_nxt = r_rd_ptr_q + 1'b1;
    always_comb begin
        o_next_tag = r_mem_q[r_rd_ptr_q][DATA_W-1 -: TAG_W];
        if (r_occ_q == '0 || (i_pop && r_occ_q == C_OCC_W'(1)))
            o_next_tag = i_wr_data[DATA_W-1 -: TAG_W];
        else if (i_pop)
            o_next_tag = r_mem_q[w_rd_nxt][DATA_W-1 -: TAG_W];
    end

    assign o_head     = r_mem_q[r_rd_ptr_q];
    assign o_occ_next = w_occ_d;
    assign o_full     = (r_occ_q == C_OCC_W'(DEPTH));
    assign o_empty    = (r_occ_q == '0);

endmodule

`default_nettype wire

// File: rtl/dest_demux.sv
// ============================================================================
//  Module      : dest_demux
//  Description : Steers buffered words to egress FIFOs P4..P7 by their
//                destination field, with per-destination counters and FSM.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dest_demux
    import dest_demux_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              almost_full_P4,
    input  logic              almost_full_P5,
    input  logic              almost_full_P6,
    input  logic              almost_full_P7,
    output logic              push_P4,
    output logic              push_P5,
    output logic              push_P6,
    output logic              push_P7,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  cnt_P4,
    output logic [CNT_W-1:0]  cnt_P5,
    output logic [CNT_W-1:0]  cnt_P6,
    output logic [CNT_W-1:0]  cnt_P7,
    output logic [1:0]        state
);

    localparam int C_OCC_W = $clog2(DEPTH) + 1;

    logic [C_NUM_DEST-1:0]             w_af;
    logic [DATA_W-1:0]                 w_head;
    logic [C_DEST_W-1:0]               w_head_dest;
    logic [C_DEST_W-1:0]               w_next_tag;
    logic [C_OCC_W-1:0]                w_occ_next;
    logic                              w_full, w_empty;
    logic                              w_accept, w_dispatch;
    logic [C_NUM_DEST-1:0]             w_push_d, r_push_q;
    logic [DATA_W-1:0]                 w_out_data_d, r_out_data_q;
    state_t                            w_state_d, r_state_q;
    logic [C_NUM_DEST-1:0][CNT_W-1:0]  w_cnt;

    assign w_af = {almost_full_P7, almost_full_P6, almost_full_P5, almost_full_P4};

    hold_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TAG_W  (C_DEST_W)
    ) u_hold_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .i_push     (w_accept),
        .i_pop      (w_dispatch),
        .i_wr_data  (in_data),
        .o_head     (w_head),
        .o_next_tag (w_next_tag),
        .o_occ_next (w_occ_next),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign in_ready    = ~w_full;
    assign w_head_dest = w_head[DATA_W-1 -: C_DEST_W];
    assign w_accept    = in_valid & in_ready & ~flush;
    assign w_dispatch  = ~w_empty & ~flush & ~w_af[w_head_dest];

    always_comb begin
        w_push_d     = '0;
        w_out_data_d = r_out_data_q;
        if (w_dispatch) begin
            w_push_d[w_head_dest] = 1'b1;
            w_out_data_d          = w_head;
        end
    end

    // State reflects the buffer as it stands after this edge.
    always_comb begin
        if (w_occ_next == '0)
            w_state_d = ST_IDLE;
        else if (w_af[w_next_tag])
            w_state_d = ST_BLOCKED;
        else
            w_state_d = ST_RUN;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_push_q     <= '0;
            r_out_data_q <= '0;
            r_state_q    <= ST_IDLE;
        end else begin
            r_push_q     <= w_push_d;
            r_out_data_q <= w_out_data_d;
            r_state_q    <= w_state_d;
        end
    end

    for (genvar i = 0; i < C_NUM_DEST; i++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt_q, w_cnt_d;

        always_comb begin
            w_cnt_d = r_cnt_q;
            if (w_push_d[i]) w_cnt_d = r_cnt_q + 1'b1;
        end

        always_ff @(posedge clk) begin
            if (!reset) r_cnt_q <= '0;
            else        r_cnt_q <= w_cnt_d;
        end

        assign w_cnt[i] = r_cnt_q;
    end

    assign {push_P7, push_P6, push_P5, push_P4} = r_push_q;
    assign out_data = r_out_data_q;
    assign cnt_P4   = w_cnt[0];
    assign cnt_P5   = w_cnt[1];
    assign cnt_P6   = w_cnt[2];
    assign cnt_P7   = w_cnt[3];
    assign state    = r_state_q;

endmodule

`default_nettype wire

// File: tb/tb_dest_demux.sv
// ============================================================================
//  Module      : tb_dest_demux
//  Description : Directed self-checking bench for dest_demux.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dest_demux;

    logic       clk = 1'b0;
    logic       reset, flush, in_valid, in_ready;
    logic [9:0] in_data, out_data;
    logic       af4, af5, af6, af7;
    logic       p4, p5, p6, p7;
    logic [7:0] c4, c5, c6, c7;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    int n_push;

    dest_demux #(.DATA_W(10), .DEPTH(4), .CNT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .almost_full_P4 (af4),
        .almost_full_P5 (af5),
        .almost_full_P6 (af6),
        .almost_full_P7 (af7),
        .push_P4        (p4),
        .push_P5        (p5),
        .push_P6        (p6),
        .push_P7        (p7),
        .out_data       (out_data),
        .cnt_P4         (c4),
        .cnt_P5         (c5),
        .cnt_P6         (c6),
        .cnt_P7         (c7),
        .state          (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pushes();
        return {p7, p6, p5, p4};
    endfunction

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        {af4, af5, af6, af7} = 4'b0000;

        // Reset then idle
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("reset_push", pushes(), 4'b0000);
        chk("reset_cnt", {c7, c6, c5, c4}, 32'h0);
        chk("reset_ready", in_ready, 1'b1);
        chk("reset_state", state, 2'b00);
        chk("reset_out", out_data, 10'h000);

        // Routing
        in_valid = 1'b1; in_data = 10'h0AA; tick();
        chk("rt_first_nopush", pushes(), 4'b0000);
        chk("rt_state_run", state, 2'b01);
        in_data = 10'h155; tick();
        chk("rt_push4", pushes(), 4'b0001);
        chk("rt_data4", out_data, 10'h0AA);
        in_data = 10'h2F0; tick();
        chk("rt_push5", pushes(), 4'b0010);
        chk("rt_data5", out_data, 10'h155);
        in_data = 10'h3FF; tick();
        chk("rt_push6", pushes(), 4'b0100);
        chk("rt_data6", out_data, 10'h2F0);
        in_valid = 1'b0; tick();
        chk("rt_push7", pushes(), 4'b1000);
        chk("rt_data7", out_data, 10'h3FF);
        chk("rt_state_idle", state, 2'b00);
        tick();
        chk("rt_quiet", pushes(), 4'b0000);
        chk("rt_cnt", {c7, c6, c5, c4}, 32'h01010101);

        // Backpressure and head-of-line blocking
        af5 = 1'b1;
        in_valid = 1'b1; in_data = 10'h101; tick();
        chk("bp_state1", state, 2'b10);
        in_data = 10'h002; tick();
        chk("bp_nopush1", pushes(), 4'b0000);
        in_valid = 1'b0; tick();
        chk("bp_nopush2", pushes(), 4'b0000);
        chk("bp_state2", state, 2'b10);
        af5 = 1'b0; tick();
        chk("bp_push5", pushes(), 4'b0010);
        chk("bp_data5", out_data, 10'h101);
        chk("bp_state_run", state, 2'b01);
        tick();
        chk("bp_push4", pushes(), 4'b0001);
        chk("bp_data4", out_data, 10'h002);
        chk("bp_state_idle", state, 2'b00);
        chk("bp_cnt", {c5, c4}, 16'h0202);

        // Full buffer
        af4 = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("full_ready_pre", in_ready, 1'b1);
            in_data = 10'h011 + 10'(k);
            tick();
        end
        chk("full_ready0", in_ready, 1'b0);
        in_data = 10'h015; tick();
        chk("full_ready_held", in_ready, 1'b0);
        chk("full_nopush", pushes(), 4'b0000);
        af4 = 1'b0; tick();
        chk("full_push_first", pushes(), 4'b0001);
        chk("full_data_first", out_data, 10'h011);
        chk("full_ready1", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("full_data2", out_data, 10'h012);
        for (int k = 3; k <= 5; k++) begin
            tick();
            chk("full_push_k", pushes(), 4'b0001);
            chk("full_data_k", out_data, 10'h010 + 10'(k));
        end
        tick();
        chk("full_drained", pushes(), 4'b0000);
        chk("full_cnt4", c4, 8'd7);

        // Flush mid-operation
        af6 = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 10'h200 + 10'(k);
            tick();
        end
        chk("fl_blocked", state, 2'b10);
        in_data = 10'h203; flush = 1'b1; tick();
        chk("fl_state", state, 2'b00);
        chk("fl_nopush", pushes(), 4'b0000);
        flush = 1'b0; in_valid = 1'b0; af6 = 1'b0; tick();
        chk("fl_nopush2", pushes(), 4'b0000);
        chk("fl_state2", state, 2'b00);
        chk("fl_cnt", {c7, c6, c5, c4}, 32'h01010207);

        // Reset mid-operation
        af6 = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 10'h210 + 10'(k);
            tick();
        end
        reset = 1'b0; tick();
        chk("rs_cnt", {c7, c6, c5, c4}, 32'h0);
        chk("rs_state", state, 2'b00);
        chk("rs_out", out_data, 10'h000);
        reset = 1'b1; in_valid = 1'b0; af6 = 1'b0; tick();
        chk("rs_nopush", pushes(), 4'b0000);
        chk("rs_ready", in_ready, 1'b1);

        // Counter wrap on P7 with sustained throughput
        n_push = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 256; k++) begin
            in_data = 10'h300 + 10'(k);
            tick();
            if (p7) n_push++;
        end
        chk("wr_throughput", n_push, 255);
        chk("wr_cnt255", c7, 8'd255);
        in_valid = 1'b0; tick();
        chk("wr_last_push", pushes(), 4'b1000);
        chk("wr_last_data", out_data, 10'h3FF);
        chk("wr_cnt0", c7, 8'd0);
        tick();
        chk("wr_idle", state, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dest_demux.md
# dest_demux

Output-side demultiplexer between the round-robin arbiter and the four egress FIFOs P4–P7. It accepts 10-bit words through a valid/ready handshake into a 4-entry holding buffer. It steers each word to the egress FIFO selected by bits [9:8], and respects that FIFO's almost_full. It also keeps per-destination wrap-around word counters and exposes its dispatch state for debug.

## Interface
- DATA_W, 10, word width; bits [DATA_W-1:DATA_W-2] are the destination index
- DEPTH, 4, holding-buffer entries (power of two)
- CNT_W, 8, width of each per-destination counter
- Reset is `reset`, synchronous, active-low. The clock is `clk`.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-low reset
- flush  in  1  synchronous buffer clear; no pushes for discarded words
- in_valid  in  1  arbiter presents in_data
- in_data  in  DATA_W  word from arbiter
- in_ready  out  1  buffer can accept (registered)
- almost_full_P4..almost_full_P7  in  1 each  egress FIFO backpressure
- push_P4..push_P7  out  1 each  one-hot push strobe to egress FIFO
- out_data  out  DATA_W  word shared by all egress FIFOs, valid while any push_Px=1
- cnt_P4..cnt_P7  out  CNT_W each  words pushed per destination, modulo 2^CNT_W
- state  out  2  00 IDLE, 01 RUN, 10 BLOCKED

## Operation
- Holding buffer: circular FIFO of DEPTH entries.
  - Pointers are log2(DEPTH) bits and wrap.
  - Occupancy is log2(DEPTH)+1 bits.
- Accept: on an edge where in_valid=1 and in_ready=1, write in_data at the tail.
- in_ready = (occupancy != DEPTH). It is computed from the registered occupancy, so a full buffer refuses input even in a cycle where it dispatches.
- Dispatch decision each cycle, using the head destination d = head[9:8]:
  - Dispatch when occupancy != 0, flush=0 and almost_full_P(4+d)=0.
  - Next edge: pop head, out_data<=head, push_P(4+d)<=1, all other push_Px<=0, cnt_P(4+d)<=cnt+1.
- No dispatch: all push_Px<=0; out_data holds its last value.
- Head-of-line blocking is intentional; no reordering.
- Simultaneous accept and dispatch: both happen and occupancy is unchanged.
- Flush: on the edge with flush=1:
  - pointers and occupancy go to 0, and pushes go to 0;
  - counters are unchanged;
  - a concurrent in_valid is dropped.
- FSM, registered, evaluated with post-edge values:
  - IDLE: occupancy==0. Goes to RUN when a word is accepted.
  - RUN: occupancy>0 and head destination not almost_full. Goes to BLOCKED when the head destination asserts almost_full. Goes to IDLE when the last word is dispatched and nothing is accepted.
  - BLOCKED: occupancy>0 and head destination almost_full. Goes to RUN when almost_full drops.
  - Any state goes to IDLE on flush or reset.
- Counters wrap from 2^CNT_W-1 to 0 silently.

## Timing
- Reset (reset=0 at an edge) sets:
  - in_ready=1;
  - push_P4..P7=0, out_data=0;
  - cnt_P4..P7=0, state=IDLE;
  - buffer empty.
- Reset overrides flush and in_valid. Reset mid-operation discards all buffered words with no pushes.
- Latency:
  - A word accepted at edge t into an empty buffer appears as push high in the cycle after edge t+1.
  - So a push is visible at the earliest 1 cycle after the accepting edge.
- Throughput: 1 word/cycle sustained when the destination stays non-almost_full.
- almost_full sampled in cycle c blocks the push at edge c+1. Egress FIFOs must reserve at least 1 slot beyond the almost_full threshold.
- Push strobes last exactly 1 cycle per word; back-to-back words produce consecutive strobes.

## Structure
- Shared package dest_demux_pkg holds:
  - state encodings ST_IDLE=2'b00, ST_RUN=2'b01, ST_BLOCKED=2'b10;
  - destination field position constants.
- One sub-module is natural: `hold_fifo` (parameterised DATA_W/DEPTH circular buffer with full/empty/occupancy). The demux, counters and FSM live in the top.

## Test plan
- Reset then idle:
  - Stimulus: hold reset=0 for 2 cycles, then release with in_valid=0.
  - Required response: all pushes 0, counters 0, in_ready=1, state=00.
- Routing:
  - Stimulus: send 0x0AA, 0x155, 0x2F0, 0x3FF on consecutive cycles.
  - Required response: push_P4, P5, P6, P7 pulse in that order, one per cycle; out_data matches each word; each counter =1.
- Backpressure and blocking:
  - Stimulus: with almost_full_P5=1, send 0x101 then 0x002.
  - Required response: state=10, no pushes, 0x002 stays behind the head.
  - Stimulus: drop almost_full_P5.
  - Required response: push_P5 with 0x101 on the next cycle, then push_P4 with 0x002.
- Full buffer:
  - Stimulus: block P4 and send 5 words to dest 0.
  - Required response: in_ready=0 after 4 are accepted; the 5th is held off until the first dispatch.
- Flush and reset mid-operation:
  - Stimulus: fill 3 words, then pulse flush.
  - Required response: no pushes, state=00, counters unchanged.
  - Stimulus: repeat the fill, then pulse reset.
  - Required response: counters=0.
- Counter wrap:
  - Stimulus: 256 words to dest 3.
  - Required response: cnt_P7 returns to 0.
